// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//   Instruction-fetch stage. Holds the PC, drives the instruction ROM
//   (combinational read, same-cycle answer) and registers each fetched word,
//   together with its PC, into the IF/ID outputs consumed by decode.
//   Supports ID stalls, MIPS branches with a delay slot, pipeline flushes and
//   flags misaligned or out-of-range fetch addresses.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   stall_i          hold PC and IF/ID outputs
//   branch_flag_i    branch resolved in ID; redirect after the delay slot
//   branch_target_i  branch target byte address
//   flush_i          exception/ERET flush; redirect immediately
//   flush_pc_i       flush redirect address
//   rom_ce_o         ROM chip enable
//   rom_addr_o       ROM byte address (the PC register)
//   rom_inst_i       ROM instruction word, valid in the same cycle
//   id_pc_o          PC of the instruction presented to ID
//   id_inst_o        instruction presented to ID
//   id_valid_o       id_* hold a real instruction
//   id_adel_o        presented fetch had a bad PC (address error on load)
//   dbg_state_o      FSM state (0 = S_BOOT, 1 = S_RUN)
//
// Handshake: there is no valid/ready pair toward the ROM; the ROM answers
// whenever rom_ce_o is high. Toward ID, stall_i is the back-pressure signal:
// while it is high the IF/ID register and the PC hold their values.
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          ROM_WORDS_LOG2 = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   output logic        rom_ce_o,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_inst_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o,
   output logic        id_valid_o,
   output logic        id_adel_o,
   output logic        dbg_state_o
);

   typedef enum logic {
      S_BOOT = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic        id_valid_q, id_valid_d;
   logic        id_adel_q, id_adel_d;
   logic        bad_pc;

   // Misaligned, or any bit above the ROM's byte-address range is set.
   // Out-of-range PCs are flagged rather than aliased into the ROM.
   assign bad_pc = (pc_q[1:0] != 2'b00) ||
                   ((pc_q >> (ROM_WORDS_LOG2 + 2)) != 32'd0);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;
      id_adel_d  = id_adel_q;

      case (state_q)
         S_BOOT: begin
            // One idle cycle after reset release; redirect inputs ignored.
            state_d = S_RUN;
         end
         S_RUN: begin
            if (flush_i) begin
               // The word being fetched this cycle is dropped.
               pc_d       = flush_pc_i;
               id_inst_d  = 32'd0;
               id_valid_d = 1'b0;
               id_adel_d  = 1'b0;
            end else if (!stall_i) begin
               // A branch seen during a stall is ignored: ID re-asserts it.
               id_pc_d    = pc_q;
               id_inst_d  = bad_pc ? 32'd0 : rom_inst_i;
               id_valid_d = 1'b1;
               id_adel_d  = bad_pc;
               // The word captured alongside a branch is its delay slot.
               pc_d       = branch_flag_i ? branch_target_i : pc_q + 32'd4;
            end
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_PC;
         id_pc_q    <= 32'd0;
         id_inst_q  <= 32'd0;
         id_valid_q <= 1'b0;
         id_adel_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
         id_valid_q <= id_valid_d;
         id_adel_q  <= id_adel_d;
      end
   end

   assign rom_ce_o    = (state_q == S_RUN) && !bad_pc;
   assign rom_addr_o  = pc_q;
   assign id_pc_o     = id_pc_q;
   assign id_inst_o   = id_inst_q;
   assign id_valid_o  = id_valid_q;
   assign id_adel_o   = id_adel_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
//   Directed and randomized stimulus for inst_fetch_unit with a behavioural
//   model of the fetch stage and a combinational ROM model.
// ---------------------------------------------------------------------------
module tb_inst_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          ROM_LOG2  = 10;
   localparam int          ROM_WORDS = 1 << ROM_LOG2;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        stall_i, branch_flag_i, flush_i;
   logic [31:0] branch_target_i, flush_pc_i;
   logic        rom_ce_o;
   logic [31:0] rom_addr_o, rom_inst_i;
   logic [31:0] id_pc_o, id_inst_o;
   logic        id_valid_o, id_adel_o, dbg_state_o;

   inst_fetch_unit #(.RESET_PC(RESET_PC), .ROM_WORDS_LOG2(ROM_LOG2)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .branch_flag_i   (branch_flag_i),
      .branch_target_i (branch_target_i),
      .flush_i         (flush_i),
      .flush_pc_i      (flush_pc_i),
      .rom_ce_o        (rom_ce_o),
      .rom_addr_o      (rom_addr_o),
      .rom_inst_i      (rom_inst_i),
      .id_pc_o         (id_pc_o),
      .id_inst_o       (id_inst_o),
      .id_valid_o      (id_valid_o),
      .id_adel_o       (id_adel_o),
      .dbg_state_o     (dbg_state_o)
   );

   // ---------------- ROM model ----------------
   logic [31:0] rom_mem [ROM_WORDS];
   assign rom_inst_i = rom_ce_o ? rom_mem[rom_addr_o[ROM_LOG2+1:2]] : 32'd0;

   // ---------------- reference model ----------------
   bit          m_boot;
   logic [31:0] m_pc, m_id_pc, m_id_inst;
   logic        m_id_valid, m_id_adel;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic bit is_bad(input logic [31:0] a);
      return (a % 4 != 0) || (a >= ROM_WORDS * 4);
   endfunction

   task automatic model_reset();
      m_boot = 1; m_pc = RESET_PC;
      m_id_pc = 0; m_id_inst = 0; m_id_valid = 0; m_id_adel = 0;
   endtask

   task automatic model_edge(input logic st, input logic br, input logic [31:0] tgt,
                             input logic fl, input logic [31:0] fpc);
      if (m_boot) begin
         m_boot = 0;
      end else if (fl) begin
         m_pc = fpc; m_id_valid = 0; m_id_inst = 0; m_id_adel = 0;
      end else if (!st) begin
         m_id_pc    = m_pc;
         m_id_adel  = is_bad(m_pc);
         m_id_inst  = m_id_adel ? 32'd0 : rom_mem[m_pc / 4];
         m_id_valid = 1;
         m_pc       = br ? tgt : m_pc + 32'd4;
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".state"},    {31'd0, dbg_state_o}, {31'd0, !m_boot});
      check({tag, ".rom_addr"}, rom_addr_o, m_pc);
      check({tag, ".rom_ce"},   {31'd0, rom_ce_o}, {31'd0, !m_boot && !is_bad(m_pc)});
      check({tag, ".id_pc"},    id_pc_o, m_id_pc);
      check({tag, ".id_inst"},  id_inst_o, m_id_inst);
      check({tag, ".id_valid"}, {31'd0, id_valid_o}, {31'd0, m_id_valid});
      check({tag, ".id_adel"},  {31'd0, id_adel_o}, {31'd0, m_id_adel});
   endtask

   // ---------------- driver ----------------
   // Inputs change at the falling edge, model and DUT advance on the rising
   // edge, outputs are checked at the next falling edge.
   task automatic step(input string tag, input logic st, input logic br,
                       input logic [31:0] tgt, input logic fl, input logic [31:0] fpc);
      stall_i = st; branch_flag_i = br; branch_target_i = tgt;
      flush_i = fl; flush_pc_i = fpc;
      @(posedge clk);
      model_edge(st, br, tgt, fl, fpc);
      @(negedge clk);
      check_all(tag);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = {20'd0, $urandom_range(0, ROM_WORDS - 1) * 4};
      if ($urandom_range(0, 9) == 0) a = $urandom;
      return a;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = $urandom;
      stall_i = 0; branch_flag_i = 0; flush_i = 0;
      branch_target_i = 0; flush_pc_i = 0;

      // reset
      rst = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst = 1'b1;
      check_all("boot");

      // sequential fetch 0x0 .. 0xC, reaching pc 0x10
      repeat (5) step("seq", 0, 0, 0, 0, 0);

      // stall three cycles at 0x10, then resume to 0x20
      repeat (3) step("stall", 1, 1, 32'h300, 0, 0);
      repeat (4) step("resume", 0, 0, 0, 0, 0);

      // branch at 0x20 to 0x40 with delay slot
      step("branch", 0, 1, 32'h40, 0, 0);
      step("after_branch", 0, 0, 0, 0, 0);

      // flush wins over stall and branch
      step("flush", 1, 1, 32'h200, 1, 32'h180);
      step("after_flush", 0, 0, 0, 0, 0);
      step("after_flush2", 0, 0, 0, 0, 0);

      // misaligned target, then out-of-range target
      step("br_mis", 0, 1, 32'h42, 0, 0);
      step("br_range", 0, 1, 32'h1000, 0, 0);
      step("range_cap", 0, 0, 0, 0, 0);

      // PC wrap at the top of the address space
      step("flush_top", 0, 0, 0, 1, 32'hFFFF_FFFC);
      step("wrap", 0, 0, 0, 0, 0);
      step("wrapped", 0, 0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 200; i++) begin
         step("rand",
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 3) == 0, rand_addr(),
              $urandom_range(0, 12) == 0, rand_addr());
      end

      // asynchronous reset between edges at pc 0x8
      step("flush_8", 0, 0, 0, 1, 32'h8);
      #2 rst = 1'b0;
      #1 model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b1;
      check_all("rst_boot");
      repeat (4) step("post_rst", 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
